// File: rtl/flow_step_gen_if.sv
// Button inputs and step/status outputs of the LED flow step-rate generator.
interface flow_step_gen_if;
    logic       btn_speed;
    logic       btn_pause;
    logic       step_tick;
    logic [1:0] speed_sel;
    logic       paused;

    modport master (
        output btn_speed,
        output btn_pause,
        input  step_tick,
        input  speed_sel,
        input  paused
    );

    modport slave (
        input  btn_speed,
        input  btn_pause,
        output step_tick,
        output speed_sel,
        output paused
    );
endinterface

// File: rtl/flow_step_gen.sv
// Step-rate generator: one-cycle step_tick every DIV_BASE>>speed_sel cycles, speed cycled by a debounced button.
// Define FLOW_PAUSE_EN to build the debounced pause button that freezes stepping.
module flow_step_gen #(
    parameter int DIV_BASE     = 12_500_000,
    parameter int DEBOUNCE_CYC = 250_000,
    parameter int CNT_W        = 24
) (
    input  logic           clk,
    input  logic           rst,
    flow_step_gen_if.slave bus
);

`ifdef FLOW_PAUSE_EN
    localparam int NBTN = 2;
`else
    localparam int NBTN = 1;
`endif
    localparam int DEB_W = $clog2(DEBOUNCE_CYC);

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] press;

`ifdef FLOW_PAUSE_EN
    assign btn_raw = {bus.btn_pause, bus.btn_speed};
`else
    logic unused_btn_pause;
    assign unused_btn_pause = bus.btn_pause;
    assign btn_raw          = bus.btn_speed;
`endif

    // Per button: 2-FF synchronizer, hold-time debouncer, rising-edge press detect.
    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_d_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    deb_cnt_reg  <= '0;
                end else begin
                    sync1_reg    <= btn_raw[gi];
                    sync2_reg    <= sync1_reg;
                    stable_d_reg <= stable_reg;
                    if (sync2_reg == stable_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_W'(DEBOUNCE_CYC - 1)) begin
                        stable_reg  <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = stable_reg & ~stable_d_reg;
        end
    endgenerate

    logic             speed_evt;
    logic             paused_reg;
    logic             paused_next;
    logic [1:0]       speed_sel_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             step_tick_reg;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] last_cnt;
    logic             wrap;
    logic             run;

    assign speed_evt = press[0];

`ifdef FLOW_PAUSE_EN
    assign paused_next = paused_reg ^ press[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paused_reg <= 1'b0;
        end else begin
            paused_reg <= paused_next;
        end
    end
`else
    assign paused_next = 1'b0;
    assign paused_reg  = 1'b0;
`endif

    assign period   = (CNT_W + 1)'(DIV_BASE) >> speed_sel_reg;
    assign last_cnt = CNT_W'(period - 1'b1);
    assign wrap     = (cnt_reg == last_cnt);
    // The edge that enters pause already holds the counter; the edge that leaves it counts.
    assign run      = ~paused_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_sel_reg <= 2'd0;
            cnt_reg       <= '0;
            step_tick_reg <= 1'b0;
        end else begin
            speed_sel_reg <= speed_sel_reg + {1'b0, speed_evt};
            step_tick_reg <= run & wrap;
            if (speed_evt) begin
                cnt_reg <= '0;
            end else if (run) begin
                cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
            end
        end
    end

    assign bus.step_tick = step_tick_reg;
    assign bus.speed_sel = speed_sel_reg;
    assign bus.paused    = paused_reg;

endmodule

// File: tb/tb_flow_step_gen.sv
// Directed bench for flow_step_gen with DIV_BASE=16, DEBOUNCE_CYC=4, CNT_W=5.
module tb_flow_step_gen;

    logic clk;
    logic rst;
    int   test_cnt;
    int   fail_cnt;

    flow_step_gen_if bus ();

    flow_step_gen #(
        .DIV_BASE     (16),
        .DEBOUNCE_CYC (4),
        .CNT_W        (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, obs);
        end
    endtask

    // Counts falling edges until step_tick is seen high; n is the edge count.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.step_tick !== 1'b1 && n < 200);
        if (bus.step_tick !== 1'b1) check("tick_timeout", 0, 1);
    endtask

    task automatic press(input logic spd, input logic pse);
        bus.btn_speed = spd;
        bus.btn_pause = pse;
        repeat (10) @(negedge clk);
        bus.btn_speed = 1'b0;
        bus.btn_pause = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        int ticks;
        int first;
        int s6, s7, p6, p7, old_s, old_p, exp_p;

        test_cnt      = 0;
        fail_cnt      = 0;
        rst           = 1'b0;
        bus.btn_speed = 1'b0;
        bus.btn_pause = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tick", int'(bus.step_tick), 0);
        check("reset_speed", int'(bus.speed_sel), 0);
        check("reset_paused", int'(bus.paused), 0);

        // Free run at speed 0: ticks on edges 16, 32, 48, 64 after release.
        rst = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check($sformatf("run_tick_c%0d", k), int'(bus.step_tick), (k % 16 == 0) ? 1 : 0);
        end
        check("run_speed", int'(bus.speed_sel), 0);
        check("run_paused", int'(bus.paused), 0);

        // Four speed presses: 1, 2, 3, then wrap to 0.
        for (int s = 1; s <= 4; s++) begin
            press(1'b1, 1'b0);
            check($sformatf("speed_sel_p%0d", s), int'(bus.speed_sel), s % 4);
            wait_tick(n);
            wait_tick(n);
            check($sformatf("spacing_p%0d", s), n, 16 >> (s % 4));
        end

        // Three-cycle glitch must not be accepted.
        bus.btn_speed = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn_speed = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_speed", int'(bus.speed_sel), 0);

`ifdef FLOW_PAUSE_EN
        // Pause lands on the edge where the counter holds 5.
        wait_tick(n);
        repeat (15) @(negedge clk);
        bus.btn_pause = 1'b1;
        repeat (10) @(negedge clk);
        bus.btn_pause = 1'b0;
        check("pause_on", int'(bus.paused), 1);
        ticks = 0;
        repeat (100) begin
            @(negedge clk);
            ticks += int'(bus.step_tick);
        end
        check("pause_ticks", ticks, 0);
        // Resume at edge +7, counter 5 -> 15 then tick on edge +17.
        bus.btn_pause = 1'b1;
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 10) bus.btn_pause = 1'b0;
            if (bus.step_tick === 1'b1 && first == 0) first = k;
        end
        check("resume_first_tick", first, 17);
        check("pause_off", int'(bus.paused), 0);
`endif

        // Speed and pause asserted together: both take effect on edge +7.
        old_s = int'(bus.speed_sel);
        old_p = int'(bus.paused);
        bus.btn_speed = 1'b1;
        bus.btn_pause = 1'b1;
        s6 = 0; s7 = 0; p6 = 0; p7 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) begin s6 = int'(bus.speed_sel); p6 = int'(bus.paused); end
            if (k == 7) begin s7 = int'(bus.speed_sel); p7 = int'(bus.paused); end
        end
        bus.btn_speed = 1'b0;
        bus.btn_pause = 1'b0;
        repeat (8) @(negedge clk);
`ifdef FLOW_PAUSE_EN
        exp_p = 1 - old_p;
`else
        exp_p = 0;
`endif
        check("both_speed_before", s6, old_s);
        check("both_speed_after", s7, (old_s + 1) % 4);
        check("both_paused_before", p6, old_p);
        check("both_paused_after", p7, exp_p);

        // Unpause (no effect without the feature) and move to speed 2.
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("pre_reset_speed", int'(bus.speed_sel), 2);
        check("pre_reset_paused", int'(bus.paused), 0);

        // Asynchronous reset while a tick is showing.
        wait_tick(n);
        rst = 1'b0;
        #1;
        check("async_rst_tick", int'(bus.step_tick), 0);
        check("async_rst_speed", int'(bus.speed_sel), 0);
        check("async_rst_paused", int'(bus.paused), 0);
        @(negedge clk);
        rst = 1'b1;
        wait_tick(n);
        check("post_rst_first", n, 16);
        wait_tick(n);
        check("post_rst_spacing", n, 16);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/flow_step_gen.md
# flow_step_gen

Step-rate generator sitting directly upstream of the LED flow state machines. It turns the fast board clock into a one-cycle `step_tick` enable that advances the flow pattern, so the pattern logic runs on the system clock rather than on a divided clock. The rate is user-selectable through a debounced speed button cycling through four rates. An optional pause button freezes stepping.

## Interface
- `DIV_BASE`, 12_500_000: step period in clk cycles at slowest speed (speed 0); must be a multiple of 8, ≥ 8
- `DEBOUNCE_CYC`, 250_000: cycles a synchronized button level must hold before it is accepted; ≥ 2
- `CNT_W`, 24: width of period counter; must hold `DIV_BASE-1`
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `btn_speed`  input  1  raw speed button, active-high, asynchronous to clk
- `btn_pause`  input  1  raw pause button, active-high, asynchronous; ignored unless `FLOW_PAUSE_EN`
- `step_tick`  output  1  registered one-cycle step enable to the flow stage
- `speed_sel`  output  2  current speed index, 0 = slowest
- `paused`  output  1  high while stepping is frozen

## Operation
- Reset (`rst` low, asynchronous): `step_tick`=0, `speed_sel`=0, `paused`=0; period counter, synchronizers, debounce counters and stable levels all 0.
- Each button: 2-FF synchronizer → debouncer. Debouncer holds a stable level; if synced level differs from stable, a count runs; when it reaches `DEBOUNCE_CYC-1` with the level still differing, stable takes the new level. Any return to stable level clears the count.
- Press event: one-cycle pulse on a 0→1 transition of the stable level. Releases produce no event.
- Speed event: `speed_sel` ← `speed_sel`+1 mod 4 (3 wraps to 0); period counter cleared to 0 in the same cycle.
- Period: `PERIOD = DIV_BASE >> speed_sel` (speeds 0..3 → ÷1, ÷2, ÷4, ÷8).
- Period counter: when not paused, counts 0..PERIOD-1 and wraps to 0; `step_tick` is registered high for the one cycle following the counter value PERIOD-1.
- Pause event: toggles `paused`. While paused, the counter holds its value and `step_tick` stays 0. On resume, counting continues from the held value.
- Simultaneous speed and pause events in the same cycle: both applied (speed advances, counter cleared, `paused` toggles).
- Speed event while paused: `speed_sel` updates and counter clears; still no ticks until resume.
- Counter value ≥ new PERIOD cannot occur because every speed change clears the counter.

## Timing
- First `step_tick` after reset release: high for exactly one cycle, starting DIV_BASE cycles after the first active clock edge; thereafter every PERIOD cycles, never two consecutive cycles.
- Button latency: raw level change → 2 sync cycles + `DEBOUNCE_CYC` cycles → press event; `speed_sel`/`paused` update on the next edge.
- After a speed change, next `step_tick` occurs a full new PERIOD later.
- Glitches shorter than `DEBOUNCE_CYC` cycles produce no event.

## Configuration
- `FLOW_PAUSE_EN` defined: pause synchronizer, debouncer and toggle logic built; behaviour as above.
- Not defined: `btn_pause` unused, no pause logic built, `paused` tied 0, counter always runs.

## Test plan
Bench with DIV_BASE=16, DEBOUNCE_CYC=4, CNT_W=5.
- Reset then run 64 cycles → `step_tick` pulses one cycle wide, every 16 cycles, first 16 cycles after reset release; `speed_sel`=0, `paused`=0.
- Hold `btn_speed` high 10 cycles, three separate times → `speed_sel` 1, 2, 3; tick spacing 8, 4, 2; fourth press → `speed_sel`=0, spacing 16.
- `btn_speed` glitch high for 3 cycles → no event, `speed_sel` unchanged.
- With `FLOW_PAUSE_EN`: press pause with counter at 5 → `paused`=1, no ticks for 100 cycles; press again → `paused`=0, next tick 11 cycles after counting resumes.
- With `FLOW_PAUSE_EN`: speed and pause buttons asserted same cycle → `speed_sel` increments and `paused` toggles on the same edge; without the macro, `paused` stays 0.
- Assert `rst` low mid-period at `speed_sel`=2 → all outputs 0 immediately; after release, tick spacing 16.
